seg7_reader: RTL and testbench

//   Receive-side companion of the spellcounter's 7-segment output. Samples an 8-bit segment bus
//   (uo_out-style), debounces it and decodes it back to a hex digit. Tracks count steps up/down.

---
 rtl/seg7_pkg.sv | 9 +
 rtl/seg7_decode.sv | 18 +
 rtl/seg7_reader.sv | 84 ++++++++
 tb/tb_seg7_reader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment LUT (a=bit0, index = hex digit), blank pattern and seg7_reader FSM state encoding
package seg7_pkg;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, LOCKED = 2'd2} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational seg[6:0] -> {valid, digit[3:0]} lookup against SEG_LUT
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] digit
);
  always_comb begin
    valid = 1'b0;
    digit = 4'd0;
    for (int i = 0; i < 16; i++)
      if (seg == SEG_LUT[i]) begin
        valid = 1'b1;
        digit = 4'(i);
      end
  end
endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: debounce/decode a 7-seg bus (clk, rst_n sync low, ena, seg_i) into digit/valid/invalid/change/dir/change_cnt; step_err outputs live only under SEG7_READER_STEP_CHECK_EN
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       seg_i,
  output logic [3:0]       digit_o,
  output logic             digit_valid_o,
  output logic             invalid_o,
  output logic             change_o,
  output logic             dir_up_o,
  output logic [CNT_W-1:0] change_cnt_o,
  output logic             step_err_o,
  output logic [7:0]       step_err_cnt_o
);
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);
  logic [6:0] seg_q, cand;
  logic [7:0] cnt;
  state_t state, state_nx;
  logic load, commit, dec_valid, have_prev, moved;
  logic [3:0] dec_digit, step;
  logic unused_dp;
  assign unused_dp = seg_i[7];
  assign load = seg_q != cand;
  assign step = dec_digit - digit_o;
  assign moved = have_prev && dec_valid && dec_digit != digit_o;
  seg7_decode u_dec (.seg(cand), .valid(dec_valid), .digit(dec_digit));
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_nx;
  always_comb begin
    commit   = state == SETTLE && cnt == LAST;
    state_nx = load ? SETTLE : commit ? LOCKED : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      seg_q         <= SEG_BLANK;
      cand          <= SEG_BLANK;
      cnt           <= '0;
      digit_o       <= '0;
      digit_valid_o <= 1'b0;
      invalid_o     <= 1'b0;
      change_o      <= 1'b0;
      dir_up_o      <= 1'b0;
      change_cnt_o  <= '0;
      have_prev     <= 1'b0;
    end else if (ena) begin
      seg_q    <= SEG_ACTIVE_LOW ? ~seg_i[6:0] : seg_i[6:0];
      cand     <= load ? seg_q : cand;
      cnt      <= load ? 8'd0 : cnt == LAST ? cnt : cnt + 8'd1;
      change_o <= commit && moved;
      if (commit) begin
        digit_valid_o <= dec_valid;
        invalid_o     <= !dec_valid;
        if (dec_valid) begin
          digit_o   <= dec_digit;
          have_prev <= 1'b1;
        end
        if (moved) begin
          change_cnt_o <= &change_cnt_o ? change_cnt_o : change_cnt_o + 1'b1;
          dir_up_o     <= step == 4'd1 ? 1'b1 : step == 4'hF ? 1'b0 : dir_up_o;
        end
      end
    end
`ifdef SEG7_READER_STEP_CHECK_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      step_err_o     <= 1'b0;
      step_err_cnt_o <= '0;
    end else if (ena && commit && moved && step != 4'd1 && step != 4'hF) begin
      step_err_o     <= 1'b1;
      step_err_cnt_o <= &step_err_cnt_o ? step_err_cnt_o : step_err_cnt_o + 8'd1;
    end
`else
  assign step_err_o     = 1'b0;
  assign step_err_cnt_o = 8'd0;
`endif
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: run-length reference model compared every cycle, plus hand-computed checkpoints
module tb_seg7_reader;
  localparam int S = 4;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] seg_i = 8'h00;
  logic [3:0] digit_o;
  logic digit_valid_o, invalid_o, change_o, dir_up_o, step_err_o;
  logic [15:0] change_cnt_o;
  logic [7:0] step_err_cnt_o;
  int vectors = 0, miscompares = 0, pulses = 0;
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit m_init = 0, armed, pv0, pv1, cv, m_valid, m_inv, m_change, m_dir, m_have, m_err;
  logic [6:0] prev_s, pval0, pval1, cval;
  int run_len, d, diff, m_digit, m_cnt, m_errcnt;
  always #5 clk = ~clk;
  seg7_reader #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seg_i(seg_i), .digit_o(digit_o),
    .digit_valid_o(digit_valid_o), .invalid_o(invalid_o), .change_o(change_o),
    .dir_up_o(dir_up_o), .change_cnt_o(change_cnt_o), .step_err_o(step_err_o),
    .step_err_cnt_o(step_err_cnt_o)
  );
  function automatic int lookup(logic [6:0] p);
    for (int i = 0; i < 16; i++) if (lut[i] == p) return i;
    return -1;
  endfunction
  task automatic cmp(string n, int a, int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1; armed = 0; run_len = 0; prev_s = 0; pv0 = 0; pv1 = 0; pval0 = 0; pval1 = 0;
      m_valid = 0; m_inv = 0; m_change = 0; m_dir = 0; m_have = 0; m_err = 0;
      m_digit = 0; m_cnt = 0; m_errcnt = 0;
    end else if (ena) begin
      cv = pv1; cval = pval1; pv1 = pv0; pval1 = pval0;
      if (seg_i[6:0] != prev_s) begin run_len = 1; armed = 1; end
      else run_len++;
      prev_s = seg_i[6:0];
      pv0 = armed && run_len == S;
      pval0 = prev_s;
      m_change = 0;
      if (cv) begin
        d = lookup(cval);
        if (d < 0) begin
          m_valid = 0; m_inv = 1;
        end else begin
          if (m_have && d != m_digit) begin
            m_change = 1;
            if (m_cnt < 65535) m_cnt++;
            diff = (d - m_digit + 16) % 16;
            if (diff == 1) m_dir = 1;
            else if (diff == 15) m_dir = 0;
            else begin
`ifdef SEG7_READER_STEP_CHECK_EN
              m_err = 1;
              if (m_errcnt < 255) m_errcnt++;
`endif
            end
          end
          m_digit = d; m_valid = 1; m_inv = 0; m_have = 1;
        end
      end
    end
    #1;
    if (m_init) begin
      cmp("digit", int'(digit_o), m_digit);
      cmp("valid", int'(digit_valid_o), int'(m_valid));
      cmp("invalid", int'(invalid_o), int'(m_inv));
      cmp("change", int'(change_o), int'(m_change));
      cmp("dir_up", int'(dir_up_o), int'(m_dir));
      cmp("change_cnt", int'(change_cnt_o), m_cnt);
      cmp("step_err", int'(step_err_o), int'(m_err));
      cmp("step_err_cnt", int'(step_err_cnt_o), m_errcnt);
      if (change_o) pulses++;
    end
  end
  task automatic hold(logic [7:0] v, int n);
    seg_i = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic err_lit(int e, int ec);
`ifdef SEG7_READER_STEP_CHECK_EN
    cmp("lit_step_err", int'(step_err_o), e);
    cmp("lit_step_err_cnt", int'(step_err_cnt_o), ec);
`else
    cmp("lit_step_err_off", int'(step_err_o) + int'(step_err_cnt_o), 0 * (e + ec));
`endif
  endtask
  int p0;
  initial begin
    repeat (3) @(negedge clk);
    cmp("lit_reset_digit", int'(digit_o), 0);
    cmp("lit_reset_valid", int'(digit_valid_o), 0);
    rst_n = 1'b1;
    hold(8'h86, 5);
    cmp("lit_pre_commit_valid", int'(digit_valid_o), 0);
    hold(8'h86, 1);
    cmp("lit_first_digit", int'(digit_o), 1);
    cmp("lit_first_valid", int'(digit_valid_o), 1);
    cmp("lit_first_cnt", int'(change_cnt_o), 0);
    cmp("lit_first_pulses", pulses, 0);
    hold(8'h5B, 10);
    hold(8'h4F, 10);
    cmp("lit_up_digit", int'(digit_o), 3);
    cmp("lit_up_cnt", int'(change_cnt_o), 2);
    cmp("lit_up_pulses", pulses, 2);
    cmp("lit_up_dir", int'(dir_up_o), 1);
    hold(8'h71, 10);
    err_lit(1, 1);
    hold(8'h3F, 10);
    cmp("lit_wrap_up_dir", int'(dir_up_o), 1);
    hold(8'h71, 10);
    cmp("lit_wrap_down_dir", int'(dir_up_o), 0);
    hold(8'h3F, 10);
    cmp("lit_locked_cnt", int'(change_cnt_o), 6);
    hold(8'h00, 2);
    hold(8'h3F, 10);
    cmp("lit_glitch2_cnt", int'(change_cnt_o), 6);
    cmp("lit_glitch2_inv", int'(invalid_o), 0);
    hold(8'h00, 4);
    hold(8'h3F, 2);
    cmp("lit_glitch4_inv", int'(invalid_o), 1);
    cmp("lit_glitch4_digit", int'(digit_o), 0);
    hold(8'h3F, 8);
    cmp("lit_recommit_valid", int'(digit_valid_o), 1);
    cmp("lit_recommit_cnt", int'(change_cnt_o), 6);
    hold(8'h71, 10);
    hold(8'h06, 10);
    cmp("lit_bad_step_dir", int'(dir_up_o), 0);
    err_lit(1, 2);
    hold(8'h66, 10);
    cmp("lit_bad_step2_digit", int'(digit_o), 4);
    cmp("lit_bad_step2_cnt", int'(change_cnt_o), 9);
    err_lit(1, 3);
    ena = 1'b0;
    hold(8'h5B, 6);
    cmp("lit_frozen_digit", int'(digit_o), 4);
    ena = 1'b1;
    hold(8'h5B, 3);
    rst_n = 1'b0;
    @(negedge clk);
    cmp("lit_rst_digit", int'(digit_o), 0);
    cmp("lit_rst_cnt", int'(change_cnt_o), 0);
    cmp("lit_rst_flags", int'({digit_valid_o, invalid_o, change_o, dir_up_o}), 0);
    err_lit(0, 0);
    rst_n = 1'b1;
    p0 = pulses;
    hold(8'h5B, 6);
    cmp("lit_after_rst_digit", int'(digit_o), 2);
    cmp("lit_after_rst_pulse", pulses - p0, 0);
    hold(8'h5B, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
